// File: rtl/xor_frame_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module : xor_frame_parity_pkg
// Brief  : Shared types and helpers for the XOR frame parity stage.
// Rev    : 1.0
// ============================================================================
package xor_frame_parity_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] data;
        logic       last;
    } beat_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor_frame_parity_if.sv
`default_nettype none
// ============================================================================
// Module : xor_frame_parity_if
// Brief  : Beat input and frame-result output handshakes of the parity stage.
// Rev    : 1.0
// ============================================================================
interface xor_frame_parity_if #(
    parameter int CW = 4
);
    logic          in_valid;
    logic [1:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_parity;
    logic [CW-1:0] out_count;
    logic          out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_parity, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_parity, out_count
    );
endinterface
`default_nettype wire

// File: rtl/xor_frame_parity_xor_pair.sv
`default_nettype none
// ============================================================================
// Module : xor_pair
// Brief  : Combinational 2-bit XOR kernel.
// Rev    : 1.0
// ============================================================================
module xor_pair (
    input  wire logic [1:0] i_pair,
    output logic            o_bit
);
    assign o_bit = i_pair[0] ^ i_pair[1];
endmodule
`default_nettype wire

// File: rtl/xor_frame_parity.sv
`default_nettype none
// ============================================================================
// Module : xor_frame_parity
// Brief  : Folds per-beat pair XORs into one parity result per frame.
// Rev    : 1.0
// ============================================================================
module xor_frame_parity
    import xor_frame_parity_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    xor_frame_parity_if.slave  bus
);
    localparam int CW = clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] C_LAST_IDX = CW'(FRAME_LEN - 1);

    typedef struct packed {
        logic          parity;
        logic [CW-1:0] count;
    } result_t;

    state_e        r_state, w_state_nxt;
    logic          r_acc, w_acc_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    result_t       r_res, w_res_nxt;

    beat_t w_beat;
    logic  w_b;
    logic  w_ready;
    logic  w_accept;
    logic  w_end;

    assign w_beat = '{data: bus.in_data, last: bus.in_last};

    xor_pair u_xor_pair (
        .i_pair (w_beat.data),
        .o_bit  (w_b)
    );

    // In HOLD the freshly cleared accumulator takes a beat in the same cycle
    // the result is handed off, so acceptance simply follows out_ready.
    assign w_ready  = (r_state == ACCUM) | bus.out_ready;
    assign w_accept = bus.in_valid & w_ready;
    assign w_end    = w_accept & (w_beat.last | (r_count == C_LAST_IDX));

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_res_nxt   = r_res;
        if (w_accept) begin
            if (w_end) begin
                w_res_nxt.parity = r_acc ^ w_b;
                w_res_nxt.count  = r_count + CW'(1);
                w_acc_nxt        = 1'b0;
                w_count_nxt      = '0;
                w_state_nxt      = HOLD;
            end else begin
                w_acc_nxt   = r_acc ^ w_b;
                w_count_nxt = r_count + CW'(1);
                w_state_nxt = ACCUM;
            end
        end else if ((r_state == HOLD) && bus.out_ready) begin
            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ACCUM;
            r_acc   <= 1'b0;
            r_count <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_res   <= w_res_nxt;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = (r_state == HOLD);
    assign bus.out_parity = r_res.parity;
    assign bus.out_count  = r_res.count;

endmodule
`default_nettype wire
